// File: rtl/dcache_tagv_ctrl.sv
// Tag/Valid array sequencer for the 2-way D-cache: reset/flush sweep, refill writes, CACOP invalidates.
// Optional hit-invalidate statistics are enabled by defining DCACHE_TAGV_CTRL_STAT_EN.
module dcache_tagv_ctrl #(
  parameter int addr_width = 4,
  parameter int data_width = 25,
  parameter int way        = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  output logic                  busy,
  input  logic                  refill_valid,
  output logic                  refill_ready,
  input  logic [addr_width-1:0] refill_index,
  input  logic                  refill_way,
  input  logic [data_width-1:0] refill_tag,
  input  logic                  cacop_valid,
  output logic                  cacop_ready,
  input  logic [1:0]            cacop_op,
  input  logic [addr_width-1:0] cacop_index,
  input  logic                  cacop_way,
  input  logic [data_width-1:0] cacop_tag,
  output logic                  cacop_done,
  output logic                  cacop_hit,
  input  logic [addr_width-1:0] lookup_addr,
  output logic [addr_width-1:0] tagv_addr_read,
  output logic [data_width-1:0] tagv_din_compare,
  input  logic [way-1:0]        tagv_hit,
  output logic [addr_width-1:0] tagv_addr_write,
  output logic [data_width-1:0] tagv_din_write,
  output logic [1:0]            tagv_init,
  output logic [way-1:0]        tagv_we,
  output logic [way-1:0]        tagv_unvalid
`ifdef DCACHE_TAGV_CTRL_STAT_EN
  ,
  output logic [31:0]           stat_hinv_total,
  output logic [31:0]           stat_hinv_hit
`endif
);

  typedef enum logic [2:0] {SWEEP, IDLE, WRITE, HI_RD, HI_CMP, DONE} state_t;

  localparam logic [addr_width:0] CNT_ONE = 1;

  state_t                r_state;
  state_t                w_next;
  logic [addr_width:0]   r_cnt;
  logic                  r_flush;
  logic                  r_flushDone;
  logic                  r_isRefill;
  logic                  r_way;
  logic                  r_hit;
  logic [addr_width-1:0] r_idx;
  logic [data_width-1:0] r_tag;

  logic                  w_sweepLast;
  logic                  w_refillFire;
  logic                  w_cacopFire;
  logic [addr_width-1:0] w_addrRead;
  logic [addr_width-1:0] w_addrWrite;
  logic [data_width-1:0] w_dinCompare;
  logic [data_width-1:0] w_dinWrite;
  logic [1:0]            w_init;
  logic [way-1:0]        w_we;
  logic [way-1:0]        w_unvalid;

  assign w_sweepLast  = &r_cnt;
  assign busy         = (r_state != IDLE);
  assign refill_ready = !busy;
  assign cacop_ready  = !busy && !refill_valid;
  assign w_refillFire = refill_valid && refill_ready;
  assign w_cacopFire  = cacop_valid && cacop_ready;
  assign cacop_done   = (r_state == DONE) || r_flushDone;
  assign cacop_hit    = (r_state == DONE) && r_hit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= SWEEP;
      r_cnt       <= '0;
      r_flush     <= 1'b0;
      r_flushDone <= 1'b0;
      r_isRefill  <= 1'b0;
      r_way       <= 1'b0;
      r_hit       <= 1'b0;
      r_idx       <= '0;
      r_tag       <= '0;
    end else begin
      r_state     <= w_next;
      r_flushDone <= (r_state == SWEEP) && w_sweepLast && r_flush;
      case (r_state)
        SWEEP: begin
          r_cnt <= r_cnt + CNT_ONE;
          if (w_sweepLast) r_flush <= 1'b0;
        end
        IDLE: begin
          if (w_refillFire) begin
            r_isRefill <= 1'b1;
            r_idx      <= refill_index;
            r_way      <= refill_way;
            r_tag      <= refill_tag;
          end else if (w_cacopFire) begin
            r_isRefill <= 1'b0;
            r_idx      <= cacop_index;
            r_way      <= cacop_way;
            r_tag      <= cacop_tag;
            r_hit      <= 1'b0;
            if (cacop_op == 2'b10) begin
              r_cnt   <= '0;
              r_flush <= 1'b1;
            end
          end
        end
        HI_CMP: r_hit <= |tagv_hit;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      SWEEP:  if (w_sweepLast) w_next = IDLE;
      IDLE: begin
        if (w_refillFire) begin
          w_next = WRITE;
        end else if (w_cacopFire) begin
          case (cacop_op)
            2'b00:   w_next = WRITE;
            2'b01:   w_next = HI_RD;
            2'b10:   w_next = SWEEP;
            default: w_next = DONE;
          endcase
        end
      end
      WRITE:  w_next = r_isRefill ? IDLE : DONE;
      HI_RD:  w_next = HI_CMP;
      HI_CMP: w_next = DONE;
      DONE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // At most one of init/we/unvalid is ever driven since each belongs to a distinct state.
  always_comb begin
    w_addrRead   = lookup_addr;
    w_dinCompare = cacop_tag;
    w_addrWrite  = '0;
    w_dinWrite   = '0;
    w_init       = 2'b00;
    w_we         = '0;
    w_unvalid    = '0;
    case (r_state)
      SWEEP: begin
        w_init      = {1'b1, r_cnt[0]};
        w_addrWrite = r_cnt[addr_width:1];
      end
      WRITE: begin
        w_addrWrite = r_idx;
        w_dinWrite  = r_tag;
        if (r_isRefill) w_we[r_way] = 1'b1;
        else            w_unvalid[r_way] = 1'b1;
      end
      HI_RD: begin
        w_addrRead  = r_idx;
        w_addrWrite = r_idx;
      end
      HI_CMP: begin
        w_addrRead   = r_idx;
        w_addrWrite  = r_idx;
        w_dinCompare = r_tag;
        w_unvalid    = tagv_hit;
      end
      default: ;
    endcase
  end

  // The array must see an all-quiet interface while reset is held, even though the state is SWEEP.
  assign tagv_addr_read   = rstn ? w_addrRead   : '0;
  assign tagv_din_compare = rstn ? w_dinCompare : '0;
  assign tagv_addr_write  = rstn ? w_addrWrite  : '0;
  assign tagv_din_write   = rstn ? w_dinWrite   : '0;
  assign tagv_init        = rstn ? w_init       : '0;
  assign tagv_we          = rstn ? w_we         : '0;
  assign tagv_unvalid     = rstn ? w_unvalid    : '0;

`ifdef DCACHE_TAGV_CTRL_STAT_EN
  logic [31:0] r_statTotal;
  logic [31:0] r_statHit;

  // HI_CMP always proceeds to DONE, so counting there equals counting completions.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_statTotal <= '0;
      r_statHit   <= '0;
    end else if (r_state == HI_CMP) begin
      if (~&r_statTotal) r_statTotal <= r_statTotal + 32'd1;
      if ((|tagv_hit) && (~&r_statHit)) r_statHit <= r_statHit + 32'd1;
    end
  end

  assign stat_hinv_total = r_statTotal;
  assign stat_hinv_hit   = r_statHit;
`endif

endmodule

// File: tb/tb_dcache_tagv_ctrl.sv
// Self-checking bench for dcache_tagv_ctrl: directed vector table, hand-written sweep/reset
// sequences and a randomized run against a transaction-level expectation queue.
module tb_dcache_tagv_ctrl;

  localparam int AW = 4;
  localparam int DW = 25;
  localparam int T  = 'h1ABCDE;

  logic          clk = 1'b0;
  logic          rstn;
  logic          busy, refill_valid, refill_ready, refill_way;
  logic [AW-1:0] refill_index;
  logic [DW-1:0] refill_tag;
  logic          cacop_valid, cacop_ready, cacop_way, cacop_done, cacop_hit;
  logic [1:0]    cacop_op;
  logic [AW-1:0] cacop_index, lookup_addr, tagv_addr_read, tagv_addr_write;
  logic [DW-1:0] cacop_tag, tagv_din_compare, tagv_din_write;
  logic [1:0]    tagv_hit, tagv_init, tagv_we, tagv_unvalid;

  int nVec  = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  dcache_tagv_ctrl #(.addr_width(AW), .data_width(DW), .way(2)) dut (
    .clk(clk), .rstn(rstn), .busy(busy),
    .refill_valid(refill_valid), .refill_ready(refill_ready), .refill_index(refill_index),
    .refill_way(refill_way), .refill_tag(refill_tag),
    .cacop_valid(cacop_valid), .cacop_ready(cacop_ready), .cacop_op(cacop_op),
    .cacop_index(cacop_index), .cacop_way(cacop_way), .cacop_tag(cacop_tag),
    .cacop_done(cacop_done), .cacop_hit(cacop_hit), .lookup_addr(lookup_addr),
    .tagv_addr_read(tagv_addr_read), .tagv_din_compare(tagv_din_compare), .tagv_hit(tagv_hit),
    .tagv_addr_write(tagv_addr_write), .tagv_din_write(tagv_din_write), .tagv_init(tagv_init),
    .tagv_we(tagv_we), .tagv_unvalid(tagv_unvalid)
  );

  typedef struct {
    logic rv; logic [AW-1:0] ri; logic rw; logic [DW-1:0] rt;
    logic cv; logic [1:0] op; logic [AW-1:0] ci; logic cw; logic [DW-1:0] ct;
    logic [1:0] hit; logic [AW-1:0] la;
  } stim_t;

  typedef struct {
    logic busy, rr, cr; logic [1:0] init, we, unv; logic done, hit;
    logic chkW; logic [AW-1:0] aW; logic [DW-1:0] dW;
    logic chkR; logic [AW-1:0] aR;
    logic chkC; logic [DW-1:0] cmp;
    logic hiCmp, flushEnd;
  } exp_t;

  typedef struct { stim_t s; exp_t e; } vec_t;

  vec_t tbl[$];
  exp_t plan[$];
  logic pendDone;

  function automatic stim_t mkStim(int rv, int ri, int rw, int rt, int cv, int op, int ci,
                                   int cw, int ct, int hit, int la);
    stim_t s;
    s.rv = rv[0]; s.ri = ri[AW-1:0]; s.rw = rw[0]; s.rt = rt[DW-1:0];
    s.cv = cv[0]; s.op = op[1:0]; s.ci = ci[AW-1:0]; s.cw = cw[0]; s.ct = ct[DW-1:0];
    s.hit = hit[1:0]; s.la = la[AW-1:0];
    return s;
  endfunction

  function automatic exp_t mkExp(int bsy, int rr, int cr, int init, int we, int unv, int done, int hit);
    exp_t e;
    e.busy = bsy[0]; e.rr = rr[0]; e.cr = cr[0]; e.init = init[1:0]; e.we = we[1:0];
    e.unv = unv[1:0]; e.done = done[0]; e.hit = hit[0];
    e.chkW = 1'b0; e.aW = '0; e.dW = '0; e.chkR = 1'b0; e.aR = '0; e.chkC = 1'b0; e.cmp = '0;
    e.hiCmp = 1'b0; e.flushEnd = 1'b0;
    return e;
  endfunction

  function automatic exp_t idleExp(int cr);
    return mkExp(0, 1, cr, 0, 0, 0, 0, 0);
  endfunction

  function automatic exp_t withW(exp_t e, int a, int d);
    e.chkW = 1'b1; e.aW = a[AW-1:0]; e.dW = d[DW-1:0];
    return e;
  endfunction

  function automatic exp_t withR(exp_t e, int a);
    e.chkR = 1'b1; e.aR = a[AW-1:0];
    return e;
  endfunction

  function automatic exp_t withC(exp_t e, int c);
    e.chkC = 1'b1; e.cmp = c[DW-1:0];
    return e;
  endfunction

  // Sweep step k covers set k/2, way k%2.
  function automatic exp_t sweepRec(int k, logic last);
    exp_t e;
    e = withW(mkExp(1, 0, 0, 2 | (k & 1), 0, 0, 0, 0), k >> 1, 0);
    e.flushEnd = last;
    return e;
  endfunction

  task automatic addRow(input stim_t s, input exp_t e);
    vec_t v;
    v.s = s; v.e = e;
    tbl.push_back(v);
  endtask

  task automatic applyStimulus(input stim_t s);
    refill_valid = s.rv; refill_index = s.ri; refill_way = s.rw; refill_tag = s.rt;
    cacop_valid = s.cv; cacop_op = s.op; cacop_index = s.ci; cacop_way = s.cw; cacop_tag = s.ct;
    tagv_hit = s.hit; lookup_addr = s.la;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compareAll(input string tag, input exp_t e);
    checkOutput({tag, ".busy"}, 32'(busy), 32'(e.busy));
    checkOutput({tag, ".refill_ready"}, 32'(refill_ready), 32'(e.rr));
    checkOutput({tag, ".cacop_ready"}, 32'(cacop_ready), 32'(e.cr));
    checkOutput({tag, ".init"}, 32'(tagv_init), 32'(e.init));
    checkOutput({tag, ".we"}, 32'(tagv_we), 32'(e.we));
    checkOutput({tag, ".unvalid"}, 32'(tagv_unvalid), 32'(e.unv));
    checkOutput({tag, ".done"}, 32'(cacop_done), 32'(e.done));
    checkOutput({tag, ".hit"}, 32'(cacop_hit), 32'(e.hit));
    if (e.chkW) checkOutput({tag, ".addr_write"}, 32'(tagv_addr_write), 32'(e.aW));
    if (e.we != 2'b00) checkOutput({tag, ".din_write"}, 32'(tagv_din_write), 32'(e.dW));
    if (e.chkR) checkOutput({tag, ".addr_read"}, 32'(tagv_addr_read), 32'(e.aR));
    if (e.chkC) checkOutput({tag, ".din_compare"}, 32'(tagv_din_compare), 32'(e.cmp));
  endtask

  // Expects to be entered just after the clock edge that starts sweep step 0.
  task automatic sweepCheck(input string tag);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      compareAll(tag, sweepRec(k, 1'b0));
      @(posedge clk); #1;
    end
  endtask

  // Expectations are produced per accepted transaction as a queue of future cycles.
  task automatic modelStep(output exp_t e);
    if (plan.size() != 0) begin
      e = plan.pop_front();
      if (e.hiCmp) begin
        e.unv = tagv_hit;
        if (plan.size() != 0) plan[0].hit = (tagv_hit != 2'b00);
      end
      pendDone = e.flushEnd;
    end else begin
      e = withC(withR(idleExp(int'(!refill_valid)), int'(lookup_addr)), int'(cacop_tag));
      e.done = pendDone;
      pendDone = 1'b0;
      if (refill_valid) begin
        plan.push_back(withW(mkExp(1, 0, 0, 0, 1 << refill_way, 0, 0, 0), int'(refill_index),
                             int'(refill_tag)));
      end else if (cacop_valid) begin
        case (cacop_op)
          2'b00: begin
            plan.push_back(withW(mkExp(1, 0, 0, 0, 0, 1 << cacop_way, 0, 0), int'(cacop_index), 0));
            plan.push_back(mkExp(1, 0, 0, 0, 0, 0, 1, 0));
          end
          2'b01: begin
            exp_t c;
            plan.push_back(withR(withW(mkExp(1, 0, 0, 0, 0, 0, 0, 0), int'(cacop_index), 0),
                                 int'(cacop_index)));
            c = withC(withR(withW(mkExp(1, 0, 0, 0, 0, 0, 0, 0), int'(cacop_index), 0),
                            int'(cacop_index)), int'(cacop_tag));
            c.hiCmp = 1'b1;
            plan.push_back(c);
            plan.push_back(mkExp(1, 0, 0, 0, 0, 0, 1, 0));
          end
          2'b10: for (int k = 0; k < 32; k++) plan.push_back(sweepRec(k, k == 31));
          default: plan.push_back(mkExp(1, 0, 0, 0, 0, 0, 1, 0));
        endcase
      end
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    stim_t z;
    exp_t  e;
    z = mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rstn = 1'b0;
    applyStimulus(z);

    // Reset state: busy, array interface quiet.
    @(negedge clk);
    compareAll("reset", withW(mkExp(1, 0, 0, 0, 0, 0, 0, 0), 0, 0));
    @(posedge clk); #1;
    rstn = 1'b1;
    sweepCheck("pwrSweep");
    @(negedge clk);
    compareAll("pwrIdle", idleExp(1));
    @(posedge clk); #1;

    // Directed vectors: refill/CACOP arbitration, hit-invalidate hit/miss, index-invalidate, reserved.
    addRow(mkStim(1, 5, 1, T, 1, 1, 5, 0, T, 0, 2), withC(withR(idleExp(0), 2), T));
    addRow(mkStim(0, 0, 0, 0, 1, 1, 5, 0, T, 0, 2), withW(mkExp(1, 0, 0, 0, 2, 0, 0, 0), 5, T));
    addRow(mkStim(0, 0, 0, 0, 1, 1, 5, 0, T, 0, 7), withC(withR(idleExp(1), 7), T));
    addRow(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 'h5, 0, 7), withR(withW(mkExp(1, 0, 0, 0, 0, 0, 0, 0), 5, 0), 5));
    addRow(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 'h5, 2, 7),
           withC(withR(withW(mkExp(1, 0, 0, 0, 0, 2, 0, 0), 5, 0), 5), T));
    addRow(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7), mkExp(1, 0, 0, 0, 0, 0, 1, 1));
    addRow(mkStim(0, 0, 0, 0, 1, 1, 5, 0, T, 0, 1), withC(withR(idleExp(1), 1), T));
    addRow(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1), withR(withW(mkExp(1, 0, 0, 0, 0, 0, 0, 0), 5, 0), 5));
    addRow(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1),
           withC(withR(withW(mkExp(1, 0, 0, 0, 0, 0, 0, 0), 5, 0), 5), T));
    addRow(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1), mkExp(1, 0, 0, 0, 0, 0, 1, 0));
    addRow(mkStim(0, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0), withC(withR(idleExp(1), 0), 0));
    addRow(z, withW(mkExp(1, 0, 0, 0, 0, 1, 0, 0), 3, 0));
    addRow(z, mkExp(1, 0, 0, 0, 0, 0, 1, 0));
    addRow(mkStim(0, 0, 0, 0, 1, 3, 9, 0, 0, 0, 0), idleExp(1));
    addRow(z, mkExp(1, 0, 0, 0, 0, 0, 1, 0));
    addRow(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 'h77, 0, 9), withC(withR(idleExp(1), 9), 'h77));
    addRow(mkStim(1, 15, 0, 'h1FFFFFF, 0, 0, 0, 0, 0, 0, 0), idleExp(0));
    addRow(z, withW(mkExp(1, 0, 0, 0, 1, 0, 0, 0), 15, 'h1FFFFFF));
    addRow(z, idleExp(1));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].s);
      @(negedge clk);
      compareAll($sformatf("tbl%0d", i), tbl[i].e);
      @(posedge clk); #1;
    end

    // Flush-all: full sweep, then a done pulse with no hit while already idle.
    applyStimulus(mkStim(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0));
    @(negedge clk);
    compareAll("flushReq", withC(withR(idleExp(1), 0), 0));
    @(posedge clk); #1;
    applyStimulus(z);
    sweepCheck("flushSweep");
    @(negedge clk);
    compareAll("flushDone", mkExp(0, 1, 1, 0, 0, 0, 1, 0));
    @(posedge clk); #1;
    @(negedge clk);
    compareAll("flushAfter", idleExp(1));
    @(posedge clk); #1;

    // Reset at sweep step 10 of a flush: quiet at once, restart from set 0, no done pulse.
    applyStimulus(mkStim(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    applyStimulus(z);
    repeat (10) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    compareAll("midReset", withW(mkExp(1, 0, 0, 0, 0, 0, 0, 0), 0, 0));
    @(posedge clk); #1;
    rstn = 1'b1;
    sweepCheck("restartSweep");
    @(negedge clk);
    compareAll("restartIdle", idleExp(1));
    @(posedge clk); #1;

    // Randomized run against the expectation queue, starting from a fresh reset.
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    plan.delete();
    for (int k = 0; k < 32; k++) plan.push_back(sweepRec(k, 1'b0));
    pendDone = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      int nAct;
      refill_valid = ($urandom_range(0, 3) == 0);
      refill_index = AW'($urandom);
      refill_way   = 1'($urandom);
      refill_tag   = DW'($urandom);
      cacop_valid  = ($urandom_range(0, 2) == 0);
      cacop_op     = 2'($urandom_range(0, 3));
      if (cacop_op == 2'b10 && $urandom_range(0, 3) != 0) cacop_op = 2'b01;
      cacop_index  = AW'($urandom);
      cacop_way    = 1'($urandom);
      cacop_tag    = DW'($urandom);
      tagv_hit     = 2'($urandom);
      lookup_addr  = AW'($urandom);
      modelStep(e);
      @(negedge clk);
      compareAll("rand", e);
      nAct = int'(tagv_init[1]) + int'(|tagv_we) + int'(|tagv_unvalid);
      checkOutput("rand.exclusive", 32'(nAct <= 1), 32'd1);
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule

// File: doc/dcache_tagv_ctrl.md
Name: dcache_tagv_ctrl

Overview:
Sequencer and write-port arbiter for the 2-way D-cache Tag/Valid array. Runs the power-on and flush-all sweep that clears every set, services refill tag writes and CACOP invalidate operations, and owns the array's write address, write data, init, write-enable and invalidate lines. It also borrows the array's read address for hit-invalidate lookups. Sits between the D-cache main FSM and the Tag/Valid array.

Parameters:
addr_width, 4, set index width; the array has 2^addr_width sets
data_width, 25, tag width stored per way
way, 2, associativity; fixed at 2, other values unsupported

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
busy  out  1  high while any sweep or CACOP sequence is in progress
refill_valid  in  1  refill tag-write request
refill_ready  out  1  refill accepted when refill_valid && refill_ready
refill_index  in  addr_width  set to write
refill_way  in  1  target way
refill_tag  in  data_width  tag to store
cacop_valid  in  1  CACOP request
cacop_ready  out  1  CACOP accepted when cacop_valid && cacop_ready
cacop_op  in  2  00 index-invalidate, 01 hit-invalidate, 10 flush-all, 11 reserved (no-op)
cacop_index  in  addr_width  target set
cacop_way  in  1  way for index-invalidate
cacop_tag  in  data_width  compare tag for hit-invalidate
cacop_done  out  1  one-cycle pulse when a CACOP completes
cacop_hit  out  1  valid with cacop_done; 1 if hit-invalidate found a match
lookup_addr  in  addr_width  read index from the main FSM in normal operation
tagv_addr_read  out  addr_width  array read address
tagv_din_compare  out  data_width  array compare tag
tagv_hit  in  2  array hit vector
tagv_addr_write  out  addr_width  array write/valid address
tagv_din_write  out  data_width  array write data
tagv_init  out  2  array init control: 1x = clear way x[0]
tagv_we  out  2  array per-way write enable
tagv_unvalid  out  2  array per-way invalidate

Behaviour:
- States: SWEEP, IDLE, WRITE, HI_RD, HI_CMP, DONE.
- Reset:
  - State goes to SWEEP with sweep counter 0.
  - All array-control outputs are 0. cacop_done and cacop_hit are 0. busy is 1.
- SWEEP:
  - 2*2^addr_width cycles. A counter of addr_width+1 bits gives the index in bits [addr_width:1] and the way in bit 0.
  - Each cycle drives tagv_init = {1, way} and tagv_addr_write = index; we and unvalid are 0.
  - Order is set0/way0, set0/way1, set1/way0, ...
  - After the last pair, go to IDLE. If the sweep was entered by flush-all, pulse cacop_done with cacop_hit = 0 in the cycle after the last pair.
- IDLE:
  - refill_ready and cacop_ready are 1 only in IDLE with busy 0.
  - If both requests are valid, refill wins and cacop_ready drops that cycle.
  - tagv_addr_read = lookup_addr and tagv_din_compare = cacop_tag in IDLE.
- Refill:
  - On handshake, latch index, way and tag and go to WRITE.
  - WRITE lasts one cycle: tagv_we[way] = 1, tagv_din_write = tag, tagv_addr_write = index. Then return to IDLE.
  - Refill latency is 1 cycle from handshake to the write-enable cycle.
- Index-invalidate (op 00):
  - Go to WRITE with tagv_unvalid[way] = 1 and the tag unchanged (we = 0).
  - Then DONE: cacop_done = 1, cacop_hit = 0, one cycle. Then IDLE.
- Hit-invalidate (op 01):
  - HI_RD: tagv_addr_read = index, tagv_addr_write = index. Covers the 1-cycle array read latency.
  - HI_CMP: tagv_din_compare = latched tag, tagv_addr_write = index held.
    - If tagv_hit is nonzero, assert tagv_unvalid = tagv_hit in that cycle and set cacop_hit = 1.
    - Otherwise no write and cacop_hit = 0.
  - Then DONE.
  - Total: 3 cycles from handshake to cacop_done.
- Flush-all (op 10): on handshake, clear the counter and enter SWEEP.
- Reserved op (11): go straight to DONE with cacop_hit = 0.
- busy is 1 in every state except IDLE.
- At most one of tagv_init[1], |tagv_we, |tagv_unvalid is nonzero in any cycle.
- Reset asserted mid-sequence aborts the sequence:
  - No cacop_done is issued.
  - The sweep restarts from set 0.
  - Latched requests are discarded.

Optional Feature:
DCACHE_TAGV_CTRL_STAT_EN: adds two outputs, stat_hinv_total[31:0] and stat_hinv_hit[31:0].
- stat_hinv_total counts completed hit-invalidates; stat_hinv_hit counts those that hit.
- Both saturate at all-ones and are cleared by rstn (not by flush-all).
- Without the macro, these ports and the counters do not exist.

Test Plan:
- Reset release, addr_width=4 -> busy=1 for 32 cycles, tagv_init sequence 10,11 per set 0..15, then busy=0 and refill_ready=1.
- Refill idx 5, way 1, tag 0x1ABCDE -> next cycle tagv_we=2'b10, addr_write=5, din_write=0x1ABCDE; back in IDLE the cycle after.
- Refill and CACOP valid together -> refill accepted first, cacop_ready=0; CACOP accepted after WRITE.
- Hit-invalidate idx 5, tag 0x1ABCDE with array returning hit=2'b10 -> tagv_unvalid=2'b10 in HI_CMP, cacop_done with cacop_hit=1 at handshake+3; repeat with hit=00 -> unvalid=00, cacop_hit=0.
- Index-invalidate idx 3, way 0 -> unvalid=2'b01 at addr 3 for one cycle, cacop_done next cycle; flush-all -> full 32-cycle sweep, then done pulse.
- rstn low at sweep cycle 10 -> outputs zero immediately; after release the sweep restarts at set 0 and no cacop_done pulse appears.
